// File: rtl/common.sv
// Shared bus-level types: address/word widths, access size encoding and the
// request/response records exchanged with the data bus.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

endpackage

// File: rtl/instruction.sv
// Memory-stage operation codes and helpers classifying them by direction and
// access size.
package instruction;
  import common::*;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    LB  = 4'd1,
    LH  = 4'd2,
    LW  = 4'd3,
    LD  = 4'd4,
    LBU = 4'd5,
    LHU = 4'd6,
    LWU = 4'd7,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10,
    SD  = 4'd11
  } instruction_type;

  function automatic logic is_load(instruction_type op);
    return op inside {LB, LH, LW, LD, LBU, LHU, LWU};
  endfunction

  function automatic logic is_store(instruction_type op);
    return op inside {SB, SH, SW, SD};
  endfunction

  function automatic msize_t op_size(instruction_type op);
    case (op)
      LB, LBU, SB: return MSIZE1;
      LH, LHU, SH: return MSIZE2;
      LW, LWU, SW: return MSIZE4;
      default:     return MSIZE8;
    endcase
  endfunction

endpackage

// File: rtl/databus_post_align.sv
// Extracts the addressed bytes from a bus word and sign/zero-extends them
// according to the load flavour.
module databus_post_align
  import common::*, instruction::*;
(
  input  logic [2:0]      byte_offset,
  input  instruction_type op,
  input  word_t           rdata,
  output word_t           data
);

  word_t shifted;

  assign shifted = rdata >> {byte_offset, 3'b000};

  always_comb begin
    case (op)
      LB:      data = {{56{shifted[7]}},  shifted[7:0]};
      LH:      data = {{48{shifted[15]}}, shifted[15:0]};
      LW:      data = {{32{shifted[31]}}, shifted[31:0]};
      LBU:     data = {56'd0, shifted[7:0]};
      LHU:     data = {48'd0, shifted[15:0]};
      LWU:     data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/databus_pre_align.sv
// Steers low-aligned store data onto its byte lanes and builds the matching
// write strobe.
module databus_pre_align
  import common::*;
(
  input  logic [2:0] byte_offset,
  input  msize_t     size,
  input  word_t      wdata,
  output strobe_t    strobe,
  output word_t      data
);

  strobe_t size_mask;

  always_comb begin
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
  end

  assign strobe = size_mask << byte_offset;
  assign data   = wdata << {byte_offset, 3'b000};

endmodule

// File: rtl/mem_align_check.sv
// Natural-alignment check for a memory op; only the byte offset within the
// doubleword matters.
module mem_align_check
  import common::*, instruction::*;
(
  input  instruction_type op,
  input  logic [2:0]      byte_offset,
  output logic            load_misalign,
  output logic            store_misalign
);

  logic misaligned;

  always_comb begin
    case (op_size(op))
      MSIZE2:  misaligned = byte_offset[0];
      MSIZE4:  misaligned = |byte_offset[1:0];
      MSIZE8:  misaligned = |byte_offset;
      default: misaligned = 1'b0;
    endcase
  end

  assign load_misalign  = is_load(op) & misaligned;
  assign store_misalign = is_store(op) & misaligned;

endmodule

// File: rtl/dbus_access_ctrl.sv
// Memory-stage sequencer: accepts one load/store, checks alignment, runs a
// single data-bus transaction and returns an extended result or a fault.
module dbus_access_ctrl
  import common::*, instruction::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  instruction_type op,
  input  addr_t           addr,
  input  word_t           wdata,
  input  logic            flush,
  output logic            resp_valid,
  output word_t           rdata,
  output logic            load_misalign,
  output logic            store_misalign,
  output dbus_req_t       dreq,
  input  dbus_resp_t      dresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dac_state_t;

  dac_state_t      state_reg, state_next;
  instruction_type op_reg;
  addr_t           addr_reg;
  word_t           wdata_reg;
  word_t           rdata_reg;
  logic            killed_reg;
  logic            load_mis_reg, store_mis_reg;

  logic            accept;
  logic            in_load_mis, in_store_mis;
  logic            in_is_mem;
  msize_t          latched_size;
  strobe_t         store_strobe;
  word_t           store_data;
  word_t           load_data;
  logic            unused_addr_ok;

  // addr_ok carries no information here: the request is simply held until data_ok.
  assign unused_addr_ok = dresp.addr_ok;

  assign accept       = req_valid & (state_reg == IDLE) & ~flush;
  assign in_is_mem    = is_load(op) | is_store(op);
  assign latched_size = op_size(op_reg);

  mem_align_check u_align_check (
    .op             (op),
    .byte_offset    (addr[2:0]),
    .load_misalign  (in_load_mis),
    .store_misalign (in_store_mis)
  );

  databus_pre_align u_pre_align (
    .byte_offset (addr_reg[2:0]),
    .size        (latched_size),
    .wdata       (wdata_reg),
    .strobe      (store_strobe),
    .data        (store_data)
  );

  databus_post_align u_post_align (
    .byte_offset (addr_reg[2:0]),
    .op          (op_reg),
    .rdata       (dresp.data),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (in_is_mem & ~(in_load_mis | in_store_mis)) ? WAIT : RESP;
        end
      end
      WAIT: begin
        // A flush seen earlier or in the data_ok cycle itself discards the result.
        if (dresp.data_ok) begin
          state_next = (killed_reg | flush) ? IDLE : RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= NOP;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      load_mis_reg  <= 1'b0;
      store_mis_reg <= 1'b0;
      killed_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg        <= op;
        addr_reg      <= addr;
        wdata_reg     <= wdata;
        rdata_reg     <= '0;
        load_mis_reg  <= in_load_mis;
        store_mis_reg <= in_store_mis;
      end
      if ((state_reg == WAIT) && dresp.data_ok) begin
        rdata_reg <= is_load(op_reg) ? load_data : '0;
      end
      if (state_next == IDLE) begin
        killed_reg <= 1'b0;
      end else if ((state_reg == WAIT) && flush) begin
        killed_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    req_ready      = (state_reg == IDLE);
    resp_valid     = (state_reg == RESP) & ~killed_reg & ~flush;
    rdata          = resp_valid ? rdata_reg : '0;
    load_misalign  = resp_valid & load_mis_reg;
    store_misalign = resp_valid & store_mis_reg;
    dreq           = '0;
    if (state_reg == WAIT) begin
      dreq.valid  = 1'b1;
      dreq.addr   = addr_reg;
      dreq.size   = latched_size;
      dreq.strobe = is_store(op_reg) ? store_strobe : '0;
      dreq.data   = store_data;
    end
  end

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Directed bench for dbus_access_ctrl: expected responses are queued when a
// request is issued and compared when the controller pulses resp_valid.
module tb_dbus_access_ctrl;
  import common::*;
  import instruction::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  instruction_type op;
  addr_t           addr;
  word_t           wdata;
  logic            flush;
  logic            resp_valid;
  word_t           rdata;
  logic            load_misalign;
  logic            store_misalign;
  dbus_req_t       dreq;
  dbus_resp_t      dresp;

  typedef struct packed {
    word_t rdata;
    logic  lmis;
    logic  smis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dbus_access_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .op             (op),
    .addr           (addr),
    .wdata          (wdata),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .rdata          (rdata),
    .load_misalign  (load_misalign),
    .store_misalign (store_misalign),
    .dreq           (dreq),
    .dresp          (dresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input word_t r, input logic lm, input logic sm);
    exp_t e;
    e.rdata = r;
    e.lmis  = lm;
    e.smis  = sm;
    exp_q.push_back(e);
  endtask

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic issue(input instruction_type o, input addr_t a, input word_t w);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = w;
    @(negedge clk);
    req_valid = 1'b0;
    op        = NOP;
    addr      = '0;
    wdata     = '0;
  endtask

  // Holds data_ok low for lat WAIT cycles, then answers with mem.
  task automatic bus_wait(input string tag, input int lat, input word_t mem,
                          input addr_t ea, input msize_t es, input strobe_t estb,
                          input logic chk_data, input word_t ed);
    for (int i = 0; i <= lat; i++) begin
      chk({tag, "_dreq_valid"}, dreq.valid, 1);
      chk({tag, "_dreq_addr"}, dreq.addr, ea);
      chk({tag, "_dreq_size"}, dreq.size, es);
      chk({tag, "_dreq_strobe"}, dreq.strobe, estb);
      if (chk_data) chk({tag, "_dreq_data"}, dreq.data, ed);
      chk({tag, "_wait_resp_valid"}, resp_valid, 0);
      chk({tag, "_wait_req_ready"}, req_ready, 0);
      if (i == lat) begin
        dresp.data_ok = 1'b1;
        dresp.data    = mem;
      end
      @(negedge clk);
    end
    dresp.data_ok = 1'b0;
    dresp.data    = '0;
  endtask

  // Expects the completion pulse in the current cycle and compares it with the queue head.
  task automatic check_resp(input string tag);
    exp_t e;
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rdata, e.rdata);
      chk({tag, "_load_misalign"}, load_misalign, e.lmis);
      chk({tag, "_store_misalign"}, store_misalign, e.smis);
    end
    chk({tag, "_resp_req_ready"}, req_ready, 0);
    chk({tag, "_resp_dreq_valid"}, dreq.valid, 0);
    $display("resp %s: rdata=0x%h lmis=%0b smis=%0b", tag, rdata, load_misalign, store_misalign);
    @(negedge clk);
    chk({tag, "_pulse_end"}, resp_valid, 0);
    chk({tag, "_ready_again"}, req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    op        = NOP;
    addr      = '0;
    wdata     = '0;
    flush     = 1'b0;
    dresp     = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_dreq", dreq, 0);
    chk("rst_misalign", {load_misalign, store_misalign}, 0);

    // LW aligned, data_ok three cycles after dreq.valid
    push_exp(64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0);
    issue(LW, 64'h8000_0004, '0);
    bus_wait("lw", 3, 64'h8765_4321_0000_0000, 64'h8000_0004, MSIZE4, 8'h00, 1'b0, '0);
    check_resp("lw");

    // LBU vs LB on byte lane 3, minimum latency
    push_exp(64'h0000_0000_0000_00F0, 1'b0, 1'b0);
    issue(LBU, 64'h8000_0003, '0);
    bus_wait("lbu", 0, 64'h1122_3344_F0AA_BBCC, 64'h8000_0003, MSIZE1, 8'h00, 1'b0, '0);
    check_resp("lbu");
    push_exp(64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0);
    issue(LB, 64'h8000_0003, '0);
    bus_wait("lb", 0, 64'h1122_3344_F0AA_BBCC, 64'h8000_0003, MSIZE1, 8'h00, 1'b0, '0);
    check_resp("lb");

    // LH / LWU extraction
    push_exp(64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0);
    issue(LH, 64'h8000_0002, '0);
    bus_wait("lh", 1, 64'h0000_0000_8001_1234, 64'h8000_0002, MSIZE2, 8'h00, 1'b0, '0);
    check_resp("lh");
    push_exp(64'h0000_0000_8765_4321, 1'b0, 1'b0);
    issue(LWU, 64'h8000_0004, '0);
    bus_wait("lwu", 0, 64'h8765_4321_0000_0000, 64'h8000_0004, MSIZE4, 8'h00, 1'b0, '0);
    check_resp("lwu");

    // SH lane steering; store returns rdata 0 whatever the bus returns
    push_exp('0, 1'b0, 1'b0);
    issue(SH, 64'h8000_0006, 64'h0000_0000_0000_BEEF);
    bus_wait("sh", 1, 64'hDEAD_BEEF_DEAD_BEEF, 64'h8000_0006, MSIZE2, 8'hC0, 1'b1, 64'hBEEF_0000_0000_0000);
    check_resp("sh");
    push_exp('0, 1'b0, 1'b0);
    issue(SD, 64'h8000_0008, 64'h0123_4567_89AB_CDEF);
    bus_wait("sd", 0, '0, 64'h8000_0008, MSIZE8, 8'hFF, 1'b1, 64'h0123_4567_89AB_CDEF);
    check_resp("sd");

    // Misaligned accesses and a non-memory op never touch the bus
    push_exp('0, 1'b0, 1'b1);
    issue(SW, 64'h8000_0002, 64'h1234_5678);
    chk("sw_mis_no_dreq", dreq.valid, 0);
    check_resp("sw_mis");
    push_exp('0, 1'b1, 1'b0);
    issue(LD, 64'h8000_0004, '0);
    chk("ld_mis_no_dreq", dreq.valid, 0);
    check_resp("ld_mis");
    push_exp('0, 1'b0, 1'b0);
    issue(NOP, 64'h8000_0001, '0);
    chk("nop_no_dreq", dreq.valid, 0);
    check_resp("nop");

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    req_valid = 1'b1;
    op        = LD;
    addr      = 64'h8000_0000;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    op        = NOP;
    addr      = '0;
    flush     = 1'b0;
    chk("flush_idle_ready", req_ready, 1);
    chk("flush_idle_dreq", dreq.valid, 0);
    chk("flush_idle_resp", resp_valid, 0);

    // Flush in WAIT: transaction still held and completed, result dropped
    issue(LD, 64'h8000_0010, '0);
    chk("flush_wait_dreq", dreq.valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_wait_hold_valid", dreq.valid, 1);
      chk("flush_wait_hold_addr", dreq.addr, 64'h8000_0010);
      chk("flush_wait_hold_size", dreq.size, MSIZE8);
      if (i == 1) begin
        dresp.data_ok = 1'b1;
        dresp.data    = 64'hAAAA_BBBB_CCCC_DDDD;
      end
      @(negedge clk);
    end
    dresp.data_ok = 1'b0;
    dresp.data    = '0;
    chk("flush_wait_no_resp", resp_valid, 0);
    chk("flush_wait_ready", req_ready, 1);
    @(negedge clk);
    chk("flush_wait_no_resp_late", resp_valid, 0);
    $display("flush in WAIT: result discarded");

    // data_ok and flush in the same WAIT cycle
    issue(LW, 64'h8000_0020, '0);
    flush         = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'h0000_0000_1111_2222;
    @(negedge clk);
    flush         = 1'b0;
    dresp.data_ok = 1'b0;
    dresp.data    = '0;
    chk("flush_dok_no_resp", resp_valid, 0);
    chk("flush_dok_ready", req_ready, 1);
    chk("flush_dok_dreq", dreq.valid, 0);
    $display("flush with data_ok: result discarded");

    // Reset mid-WAIT, then a normal LD
    issue(LD, 64'h8000_0018, '0);
    chk("rst_wait_dreq_before", dreq.valid, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait_dreq", dreq.valid, 0);
    chk("rst_wait_ready", req_ready, 1);
    chk("rst_wait_resp", resp_valid, 0);
    push_exp(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    issue(LD, 64'h8000_0018, '0);
    bus_wait("ld_after_rst", 2, 64'h0123_4567_89AB_CDEF, 64'h8000_0018, MSIZE8, 8'h00, 1'b0, '0);
    check_resp("ld_after_rst");

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
